// File: rtl/ifft8_pkg.sv
// Shared definitions for the iterative 8-point inverse FFT.
// Holds the default widths, the conjugate (inverse-direction) Q13 twiddle
// table, the 3-bit bit-reversal helper and the controller state encoding.
package ifft8_pkg;

  localparam int DATA_W  = 24;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 13;

  // e^{+j*2*pi*k/8} for k = 0..3 in Q13; W3 real part is -0x16A1.
  localparam logic signed [TW_W-1:0] IW_REAL [0:3] = '{16'sh2000, 16'sh16A0, 16'sh0000, 16'shE95F};
  localparam logic signed [TW_W-1:0] IW_IMAG [0:3] = '{16'sh0000, 16'sh16A0, 16'sh2000, 16'sh16A0};

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ifft_bfly_comb.sv
// Combinational radix-2 DIT butterfly for the inverse transform.
// a = p + q*W, b = p - q*W, with optional divide-by-two after the add.
// Ports:
//   p_real/p_imag, q_real/q_imag : butterfly operands (two's complement)
//   w_real/w_imag                : twiddle, TW_FRAC fraction bits
//   a_real/a_imag, b_real/b_imag : results written back to p and q slots
module ifft_bfly_comb #(
  parameter int DATA_W   = ifft8_pkg::DATA_W,
  parameter int TW_W     = ifft8_pkg::TW_W,
  parameter int TW_FRAC  = ifft8_pkg::TW_FRAC,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic signed [DATA_W-1:0] p_real, p_imag, q_real, q_imag,
  input  logic signed [TW_W-1:0]   w_real, w_imag,
  output logic signed [DATA_W-1:0] a_real, a_imag, b_real, b_imag
);

  localparam int PW = DATA_W + TW_W;

  logic signed [PW-1:0]   rr, ii, ri, ir;
  logic signed [PW:0]     m_real, m_imag;
  logic signed [DATA_W:0] tw_real, tw_imag;
  logic signed [DATA_W:0] sa_real, sa_imag, sd_real, sd_imag;
  logic                   unused_prod;

  assign rr = PW'(q_real) * PW'(w_real);
  assign ii = PW'(q_imag) * PW'(w_imag);
  assign ri = PW'(q_real) * PW'(w_imag);
  assign ir = PW'(q_imag) * PW'(w_real);

  // One guard bit so the sum of the two partial products cannot wrap.
  assign m_real = {rr[PW-1], rr} - {ii[PW-1], ii};
  assign m_imag = {ri[PW-1], ri} + {ir[PW-1], ir};

  // Arithmetic shift by TW_FRAC, then keep DATA_W+1 bits.
  assign tw_real = m_real[TW_FRAC+DATA_W:TW_FRAC];
  assign tw_imag = m_imag[TW_FRAC+DATA_W:TW_FRAC];
  assign unused_prod = ^{m_real[TW_FRAC-1:0], m_imag[TW_FRAC-1:0],
                         m_real[PW:TW_FRAC+DATA_W+1], m_imag[PW:TW_FRAC+DATA_W+1]};

  assign sa_real = {p_real[DATA_W-1], p_real} + tw_real;
  assign sa_imag = {p_imag[DATA_W-1], p_imag} + tw_imag;
  assign sd_real = {p_real[DATA_W-1], p_real} - tw_real;
  assign sd_imag = {p_imag[DATA_W-1], p_imag} - tw_imag;

  generate
    if (SCALE_EN) begin : g_scale
      logic unused_lsb;
      assign unused_lsb = ^{sa_real[0], sa_imag[0], sd_real[0], sd_imag[0]};
      assign a_real = sa_real[DATA_W:1];
      assign a_imag = sa_imag[DATA_W:1];
      assign b_real = sd_real[DATA_W:1];
      assign b_imag = sd_imag[DATA_W:1];
    end else begin : g_wrap
      logic unused_msb;
      assign unused_msb = ^{sa_real[DATA_W], sa_imag[DATA_W], sd_real[DATA_W], sd_imag[DATA_W]};
      assign a_real = sa_real[DATA_W-1:0];
      assign a_imag = sa_imag[DATA_W-1:0];
      assign b_real = sd_real[DATA_W-1:0];
      assign b_imag = sd_imag[DATA_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/ifft8_iter.sv
// Iterative 8-point radix-2 DIT inverse FFT: one butterfly, 12 passes
// (3 stages x 4 butterflies) over an 8-entry complex register bank.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a bin set; bank holds the last result
// CALC  | one butterfly per cycle, cnt = 0..11
// DONE  | out_valid=1, result held until out_ready
//
// Ports:
//   clk, rstn              : clock, async active-low reset
//   in_valid / in_ready    : input handshake for x0..x7 (natural bin order)
//   out_valid / out_ready  : output handshake for y0..y7 (natural time order)
module ifft8_iter #(
  parameter int DATA_W   = ifft8_pkg::DATA_W,
  parameter int TW_W     = ifft8_pkg::TW_W,
  parameter int TW_FRAC  = ifft8_pkg::TW_FRAC,
  parameter bit SCALE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0_real, x1_real, x2_real, x3_real,
  input  logic [DATA_W-1:0] x4_real, x5_real, x6_real, x7_real,
  input  logic [DATA_W-1:0] x0_imag, x1_imag, x2_imag, x3_imag,
  input  logic [DATA_W-1:0] x4_imag, x5_imag, x6_imag, x7_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y0_real, y1_real, y2_real, y3_real,
  output logic [DATA_W-1:0] y4_real, y5_real, y6_real, y7_real,
  output logic [DATA_W-1:0] y0_imag, y1_imag, y2_imag, y3_imag,
  output logic [DATA_W-1:0] y4_imag, y5_imag, y6_imag, y7_imag
);

  import ifft8_pkg::*;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] x_real [0:7];
  logic [DATA_W-1:0] x_imag [0:7];
  logic [DATA_W-1:0] bank_real [0:7];
  logic [DATA_W-1:0] bank_imag [0:7];
  logic [2:0]        p_idx, q_idx;
  logic [1:0]        t_idx;
  logic [TW_W-1:0]   w_real, w_imag;
  logic [DATA_W-1:0] a_real, a_imag, b_real, b_imag;

  assign x_real = '{x0_real, x1_real, x2_real, x3_real, x4_real, x5_real, x6_real, x7_real};
  assign x_imag = '{x0_imag, x1_imag, x2_imag, x3_imag, x4_imag, x5_imag, x6_imag, x7_imag};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)    state_nx = CALC;
      CALC:    if (cnt == 4'd11) state_nx = DONE;
      DONE:    if (out_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         cnt <= '0;
    else if (state == CALC && cnt != 4'd11) cnt <= cnt + 4'd1;
    else                               cnt <= '0;
  end

  // Stage s = cnt[3:2], butterfly k = cnt[1:0]; span h = 1<<s.
  always_comb begin
    p_idx = '0;
    q_idx = '0;
    t_idx = '0;
    case (cnt[3:2])
      2'd0: begin
        p_idx = {cnt[1:0], 1'b0};
        q_idx = {cnt[1:0], 1'b1};
        t_idx = 2'd0;
      end
      2'd1: begin
        p_idx = {cnt[1], 1'b0, cnt[0]};
        q_idx = {cnt[1], 1'b1, cnt[0]};
        t_idx = {cnt[0], 1'b0};
      end
      default: begin
        p_idx = {1'b0, cnt[1:0]};
        q_idx = {1'b1, cnt[1:0]};
        t_idx = cnt[1:0];
      end
    endcase
  end

  assign w_real = TW_W'(IW_REAL[t_idx]);
  assign w_imag = TW_W'(IW_IMAG[t_idx]);

  ifft_bfly_comb #(
    .DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC), .SCALE_EN(SCALE_EN)
  ) u_bfly (
    .p_real(bank_real[p_idx]), .p_imag(bank_imag[p_idx]),
    .q_real(bank_real[q_idx]), .q_imag(bank_imag[q_idx]),
    .w_real(w_real), .w_imag(w_imag),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag)
  );

  // Load in bit-reversed order so the in-place DIT passes end in natural order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        bank_real[i] <= '0;
        bank_imag[i] <= '0;
      end
    end else if (state == IDLE && in_valid) begin
      for (int i = 0; i < 8; i++) begin
        bank_real[i] <= x_real[bitrev3(3'(i))];
        bank_imag[i] <= x_imag[bitrev3(3'(i))];
      end
    end else if (state == CALC) begin
      bank_real[p_idx] <= a_real;
      bank_imag[p_idx] <= a_imag;
      bank_real[q_idx] <= b_real;
      bank_imag[q_idx] <= b_imag;
    end
  end

  assign {y0_real, y1_real, y2_real, y3_real} = {bank_real[0], bank_real[1], bank_real[2], bank_real[3]};
  assign {y4_real, y5_real, y6_real, y7_real} = {bank_real[4], bank_real[5], bank_real[6], bank_real[7]};
  assign {y0_imag, y1_imag, y2_imag, y3_imag} = {bank_imag[0], bank_imag[1], bank_imag[2], bank_imag[3]};
  assign {y4_imag, y5_imag, y6_imag, y7_imag} = {bank_imag[4], bank_imag[5], bank_imag[6], bank_imag[7]};

endmodule

// File: tb/tb_ifft8_iter.sv
`timescale 1ns/1ps
module tb_ifft8_iter;

  localparam int DW = 24;
  localparam int N_RAND = 300;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] xr [8];
  logic [DW-1:0] xi [8];
  logic [DW-1:0] ysr [8];
  logic [DW-1:0] ysi [8];
  logic [DW-1:0] yur [8];
  logic [DW-1:0] yui [8];
  logic in_ready_s, out_valid_s, in_ready_u, out_valid_u;

  int n_tests = 0;
  int n_fail = 0;

  real exp_r_q[$];
  real exp_i_q[$];
  int  tol_s_q[$];
  int  tol_u_q[$];

  always #5 clk = ~clk;

  ifft8_iter #(.SCALE_EN(1'b1)) u_dut_s (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s),
    .x0_real(xr[0]), .x1_real(xr[1]), .x2_real(xr[2]), .x3_real(xr[3]),
    .x4_real(xr[4]), .x5_real(xr[5]), .x6_real(xr[6]), .x7_real(xr[7]),
    .x0_imag(xi[0]), .x1_imag(xi[1]), .x2_imag(xi[2]), .x3_imag(xi[3]),
    .x4_imag(xi[4]), .x5_imag(xi[5]), .x6_imag(xi[6]), .x7_imag(xi[7]),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .y0_real(ysr[0]), .y1_real(ysr[1]), .y2_real(ysr[2]), .y3_real(ysr[3]),
    .y4_real(ysr[4]), .y5_real(ysr[5]), .y6_real(ysr[6]), .y7_real(ysr[7]),
    .y0_imag(ysi[0]), .y1_imag(ysi[1]), .y2_imag(ysi[2]), .y3_imag(ysi[3]),
    .y4_imag(ysi[4]), .y5_imag(ysi[5]), .y6_imag(ysi[6]), .y7_imag(ysi[7])
  );

  ifft8_iter #(.SCALE_EN(1'b0)) u_dut_u (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_u),
    .x0_real(xr[0]), .x1_real(xr[1]), .x2_real(xr[2]), .x3_real(xr[3]),
    .x4_real(xr[4]), .x5_real(xr[5]), .x6_real(xr[6]), .x7_real(xr[7]),
    .x0_imag(xi[0]), .x1_imag(xi[1]), .x2_imag(xi[2]), .x3_imag(xi[3]),
    .x4_imag(xi[4]), .x5_imag(xi[5]), .x6_imag(xi[6]), .x7_imag(xi[7]),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .y0_real(yur[0]), .y1_real(yur[1]), .y2_real(yur[2]), .y3_real(yur[3]),
    .y4_real(yur[4]), .y5_real(yur[5]), .y6_real(yur[6]), .y7_real(yur[7]),
    .y0_imag(yui[0]), .y1_imag(yui[1]), .y2_imag(yui[2]), .y3_imag(yui[3]),
    .y4_imag(yui[4]), .y5_imag(yui[5]), .y6_imag(yui[6]), .y7_imag(yui[7])
  );

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Ideal IDFT (1/8 scaled) of the current x, pushed as the expected result.
  task automatic push_expect(input int tol_s, input int tol_u);
    real sr, si, ang, ar, ai;
    for (int n = 0; n < 8; n++) begin
      sr = 0.0;
      si = 0.0;
      for (int k = 0; k < 8; k++) begin
        ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        ar = $itor($signed(xr[k]));
        ai = $itor($signed(xi[k]));
        sr = sr + ar * $cos(ang) - ai * $sin(ang);
        si = si + ar * $sin(ang) + ai * $cos(ang);
      end
      exp_r_q.push_back(sr / 8.0);
      exp_i_q.push_back(si / 8.0);
    end
    tol_s_q.push_back(tol_s);
    tol_u_q.push_back(tol_u);
  endtask

  task automatic clear_x();
    for (int k = 0; k < 8; k++) begin
      xr[k] = '0;
      xi[k] = '0;
    end
  endtask

  // Hold in_valid until accepted; expectation is pushed at the accept edge.
  task automatic send(input string name, input int tol_s, input int tol_u);
    int guard = 0;
    in_valid = 1'b1;
    while (!in_ready_s && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready_s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept_timeout: in_ready=%0b after %0d cycles, want 1", name, in_ready_s, guard);
      in_valid = 1'b0;
      return;
    end
    push_expect(tol_s, tol_u);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Pops one expectation and compares both DUTs (called while out_valid=1).
  task automatic check_out(input string name);
    real er [8];
    real ei [8];
    int ts, tu, bad;
    if (tol_s_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected: out_valid=1 with no pending transform, want 0", name);
      return;
    end
    for (int n = 0; n < 8; n++) begin
      er[n] = exp_r_q.pop_front();
      ei[n] = exp_i_q.pop_front();
    end
    ts = tol_s_q.pop_front();
    tu = tol_u_q.pop_front();

    n_tests++;
    if (out_valid_u !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid_u: out_valid=%0b, want 1", name, out_valid_u);
    end

    n_tests++;
    bad = -1;
    for (int n = 7; n >= 0; n--)
      if (rabs($itor($signed(ysr[n])) - er[n]) > real'(ts) + 0.01 ||
          rabs($itor($signed(ysi[n])) - ei[n]) > real'(ts) + 0.01) bad = n;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_scaled y%0d: got (%0d,%0d) want (%.2f,%.2f) +/-%0d", name, bad,
               $signed(ysr[bad]), $signed(ysi[bad]), er[bad], ei[bad], ts);
    end

    n_tests++;
    bad = -1;
    for (int n = 7; n >= 0; n--)
      if (rabs($itor($signed(yur[n])) - 8.0 * er[n]) > real'(tu) + 0.01 ||
          rabs($itor($signed(yui[n])) - 8.0 * ei[n]) > real'(tu) + 0.01) bad = n;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_unscaled y%0d: got (%0d,%0d) want (%.2f,%.2f) +/-%0d", name, bad,
               $signed(yur[bad]), $signed(yui[bad]), 8.0 * er[bad], 8.0 * ei[bad], tu);
    end
  endtask

  task automatic collect(input string name);
    int guard = 0;
    while (!out_valid_s && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid_s) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_out_timeout: out_valid=0 after %0d cycles, want 1", name, guard);
      return;
    end
    check_out(name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_idle_zero(input string name);
    int nz = 0;
    for (int n = 0; n < 8; n++)
      if (ysr[n] !== '0 || ysi[n] !== '0 || yur[n] !== '0 || yui[n] !== '0) nz++;
    n_tests++;
    if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0 || in_ready_u !== 1'b1 || out_valid_u !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl: in_ready=%0b/%0b out_valid=%0b/%0b, want 1/1 0/0", name,
               in_ready_s, in_ready_u, out_valid_s, out_valid_u);
    end
    n_tests++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL %s_outputs: %0d nonzero y samples, want 0", name, nz);
    end
  endtask

  task automatic test_reset();
    clear_x();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset_held");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("reset_released");
  endtask

  task automatic test_impulse();
    int lat = 0;
    clear_x();
    xr[0] = 24'h001000;
    send("impulse", 0, 0);
    while (!out_valid_s && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 12) begin
      n_fail++;
      $display("FAIL impulse_latency: out_valid after %0d edges, want 12", lat);
    end
    collect("impulse");
  endtask

  task automatic test_dc();
    for (int k = 0; k < 8; k++) begin
      xr[k] = 24'h001000;
      xi[k] = '0;
    end
    send("dc", 2, 4);
    collect("dc");
  endtask

  task automatic test_single_bin();
    clear_x();
    xr[1] = 24'h008000;
    send("bin1", 2, 4);
    collect("bin1");
    clear_x();
    xi[3] = 24'hFF8000;
    send("bin3_imag", 2, 4);
    collect("bin3_imag");
  endtask

  task automatic test_backpressure();
    int guard = 0;
    int extra = 0;
    clear_x();
    xr[0] = 24'h001000;
    send("bp", 0, 0);
    while (!out_valid_s && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      xr[c] = DW'($urandom_range(1, 4000));
      @(posedge clk); #1;
      n_tests++;
      if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_ctrl cycle %0d: out_valid=%0b in_ready=%0b, want 1 0", c, out_valid_s, in_ready_s);
      end
      n_tests++;
      if ($signed(ysr[c]) !== 512 || $signed(ysi[c]) !== 0 || $signed(ysr[7]) !== 512) begin
        n_fail++;
        $display("FAIL bp_hold_data cycle %0d: y%0d=(%0d,%0d) y7=%0d, want (512,0) 512", c, c,
                 $signed(ysr[c]), $signed(ysi[c]), $signed(ysr[7]));
      end
    end
    in_valid = 1'b0;
    collect("bp");
    for (int c = 0; c < 20; c++) begin
      if (out_valid_s || !in_ready_s) extra++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL bp_no_extra_accept: %0d busy cycles after handshake, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    clear_x();
    xr[0] = 24'h001000;
    xi[2] = 24'h000800;
    send("rst_mid", 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    exp_r_q.delete();
    exp_i_q.delete();
    tol_s_q.delete();
    tol_u_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    clear_x();
    xr[0] = 24'h001000;
    send("after_rst", 0, 0);
    collect("after_rst");
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int got = 0;
    fork
      begin
        for (int v = 0; v < N_RAND; v++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          for (int k = 0; k < 8; k++) begin
            xr[k] = DW'(int'($urandom_range(0, 4095)) - 2048);
            xi[k] = DW'(int'($urandom_range(0, 4095)) - 2048);
          end
          send("random", 3, 4);
          accepted++;
        end
      end
      begin
        int cyc = 0;
        while (got < N_RAND && cyc < N_RAND * 60) begin
          out_ready = ($urandom_range(0, 1) == 1);
          if (out_valid_s && out_ready) begin
            check_out("random");
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    n_tests++;
    if (got != N_RAND || accepted != N_RAND) begin
      n_fail++;
      $display("FAIL random_count: accepted %0d received %0d, want %0d each", accepted, got, N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_single_bin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
